run_controller: RTL and testbench

// Parametrised run/command sequencer between UsbController command output and ReadoutController.

---
 rtl/run_controller.sv | 211 +++++++++++++++++++++
 tb/tb_run_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
//   Run/command sequencer between the USB command path and the readout
//   controller. Strobed host commands {op, val} are decoded into a run state
//   and an integration length. The block supports continuous runs,
//   N-frame bursts, a graceful stop at the next frame boundary, an immediate
//   abort, and deferred integration-length updates while a run is in flight.
//
// Ports
//   clk_in                  in   system clock
//   reset_n                 in   synchronous reset, active low
//   cmd[CMD_W]              in   {op[OP_W], val[VAL_W]} command word
//   cmd_valid               in   1-cycle strobe, cmd sampled this cycle
//   frame_done              in   1-cycle pulse at the end of each frame
//   running                 out  readout enable (registered)
//   integration_clock_count out  active integration length in clocks
//   frame_count[FRAME_W]    out  frames done since last START/BURST, saturating
//   state[2]                out  0 IDLE, 1 RUN_CONT, 2 RUN_BURST, 3 STOPPING
//   cmd_ack                 out  pulse one cycle after an accepted command
//   cmd_error               out  pulse one cycle after a rejected command
//
// Opcodes: 0 NOOP, 1 START, 2 STOP, 3 BURST, 4 SET_INTEG, 5 ABORT, 6/7 illegal.
// VAL_W + SCALE_SHIFT must not exceed CNT_W or the scaled value truncates.
// ---------------------------------------------------------------------------
module run_controller #(
  parameter int CMD_W         = 16,
  parameter int OP_W          = 3,
  parameter int SCALE_SHIFT   = 2,
  parameter int CNT_W         = 32,
  parameter int FRAME_W       = 16,
  parameter int DEFAULT_INTEG = 5000
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_valid,
  input  logic               frame_done,
  output logic               running,
  output logic [CNT_W-1:0]   integration_clock_count,
  output logic [FRAME_W-1:0] frame_count,
  output logic [1:0]         state,
  output logic               cmd_ack,
  output logic               cmd_error
);

  localparam int VAL_W = CMD_W - OP_W;

  localparam logic [OP_W-1:0] OP_NOOP      = OP_W'(0);
  localparam logic [OP_W-1:0] OP_START     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STOP      = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BURST     = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SET_INTEG = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ABORT     = OP_W'(5);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN_CONT  = 2'd1,
    S_RUN_BURST = 2'd2,
    S_STOPPING  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [VAL_W-1:0] val;
  } cmd_t;

  cmd_t               cmd_d;
  logic [CNT_W-1:0]   val_scaled;
  logic [FRAME_W-1:0] burst_len;
  logic               val_zero;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   integ_q, integ_n;
  logic [CNT_W-1:0]   pend_q, pend_n;
  logic               pend_vld_q, pend_vld_n;
  logic [FRAME_W-1:0] frame_q, frame_n;
  logic [FRAME_W-1:0] remain_q, remain_n;
  logic               run_q;
  logic               ack_q, ack_n;
  logic               err_q, err_n;

  assign cmd_d      = cmd;
  assign val_scaled = CNT_W'(cmd_d.val) << SCALE_SHIFT;
  // Burst length takes the low FRAME_W bits of val (zero-extended if narrower).
  assign burst_len  = FRAME_W'(cmd_d.val);
  assign val_zero   = (cmd_d.val == '0);

  // Next-state logic. Evaluated in two phases so a frame boundary and a
  // command landing in the same cycle compose correctly: the frame boundary
  // moves the machine first, then the command acts on the resulting state
  // (so a START/BURST frame_count clear wins over the increment).
  always_comb begin
    state_n    = state_q;
    integ_n    = integ_q;
    pend_n     = pend_q;
    pend_vld_n = pend_vld_q;
    frame_n    = frame_q;
    remain_n   = remain_q;
    ack_n      = 1'b0;
    err_n      = 1'b0;

    // Phase 1: frame boundary (ignored while idle).
    if (frame_done && (state_q != S_IDLE)) begin
      if (frame_q != '1) frame_n = frame_q + FRAME_W'(1);
      if (pend_vld_q) begin
        integ_n    = pend_q;
        pend_vld_n = 1'b0;
      end
      case (state_q)
        S_RUN_BURST: begin
          remain_n = remain_q - FRAME_W'(1);
          // <= 1 rather than == 1 so a burst length that truncated to zero
          // still terminates on its first frame instead of wrapping.
          if (remain_q <= FRAME_W'(1)) begin
            remain_n = '0;
            state_n  = S_IDLE;
          end
        end
        S_STOPPING: state_n = S_IDLE;
        default: ;
      endcase
    end

    // Phase 2: command, applied on top of phase 1 results.
    if (cmd_valid) begin
      case (cmd_d.op)
        OP_NOOP: ;
        OP_START: begin
          if (val_zero) begin
            err_n = 1'b1;
          end else begin
            ack_n      = 1'b1;
            integ_n    = val_scaled;
            pend_vld_n = 1'b0;
            frame_n    = '0;
            state_n    = S_RUN_CONT;
          end
        end
        OP_STOP: begin
          ack_n = 1'b1;
          if ((state_n == S_RUN_CONT) || (state_n == S_RUN_BURST))
            state_n = S_STOPPING;
        end
        OP_BURST: begin
          if (val_zero) begin
            err_n = 1'b1;
          end else begin
            ack_n    = 1'b1;
            remain_n = burst_len;
            frame_n  = '0;
            state_n  = S_RUN_BURST;
          end
        end
        OP_SET_INTEG: begin
          if (val_zero) begin
            err_n = 1'b1;
          end else begin
            ack_n = 1'b1;
            if (state_n == S_IDLE) begin
              integ_n    = val_scaled;
              pend_vld_n = 1'b0;
            end else begin
              // Deferred to the next frame boundary; last write wins.
              pend_n     = val_scaled;
              pend_vld_n = 1'b1;
            end
          end
        end
        OP_ABORT: begin
          ack_n      = 1'b1;
          state_n    = S_IDLE;
          pend_vld_n = 1'b0;
          remain_n   = '0;
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      integ_q    <= CNT_W'(DEFAULT_INTEG);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      frame_q    <= '0;
      remain_q   <= '0;
      run_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      integ_q    <= integ_n;
      pend_q     <= pend_n;
      pend_vld_q <= pend_vld_n;
      frame_q    <= frame_n;
      remain_q   <= remain_n;
      run_q      <= (state_n != S_IDLE);
      ack_q      <= ack_n;
      err_q      <= err_n;
    end
  end

  assign running                 = run_q;
  assign integration_clock_count = integ_q;
  assign frame_count             = frame_q;
  assign state                   = state_q;
  assign cmd_ack                 = ack_q;
  assign cmd_error               = err_q;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        frame_done;
  logic        running;
  logic [31:0] integration_clock_count;
  logic [15:0] frame_count;
  logic [1:0]  state;
  logic        cmd_ack;
  logic        cmd_error;

  int checks   = 0;
  int failures = 0;

  // Reference model: run state as a small integer, plain counters.
  int m_state, m_integ, m_fc, m_rem, m_pend_val;
  bit m_pend, exp_ack, exp_err;

  run_controller dut (
    .clk_in(clk_in), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .frame_done(frame_done), .running(running),
    .integration_clock_count(integration_clock_count),
    .frame_count(frame_count), .state(state), .cmd_ack(cmd_ack), .cmd_error(cmd_error)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    m_state = 0; m_integ = 5000; m_fc = 0; m_rem = 0;
    m_pend = 0; m_pend_val = 0; exp_ack = 0; exp_err = 0;
  endtask

  task automatic model_step(bit v, int op, int val, bit fd);
    exp_ack = 0; exp_err = 0;
    if (fd && m_state != 0) begin
      if (m_fc < 65535) m_fc++;
      if (m_pend) begin m_integ = m_pend_val; m_pend = 0; end
      if (m_state == 2) begin
        m_rem--;
        if (m_rem <= 0) begin m_rem = 0; m_state = 0; end
      end else if (m_state == 3) m_state = 0;
    end
    if (v) begin
      if (op >= 6 || ((op == 1 || op == 3 || op == 4) && val == 0)) exp_err = 1;
      else if (op != 0) begin
        exp_ack = 1;
        case (op)
          1: begin m_integ = val * 4; m_pend = 0; m_fc = 0; m_state = 1; end
          2: if (m_state == 1 || m_state == 2) m_state = 3;
          3: begin m_rem = val; m_fc = 0; m_state = 2; end
          4: if (m_state == 0) m_integ = val * 4;
             else begin m_pend = 1; m_pend_val = val * 4; end
          5: begin m_state = 0; m_pend = 0; m_rem = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cyc(bit v, int op, int val, bit fd);
    @(negedge clk_in);
    cmd_valid = v; cmd = {3'(op), 13'(val)}; frame_done = fd;
    @(posedge clk_in);
    model_step(v, op, val, fd);
    #1;
    cmd_valid = 0; frame_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_n = 0; cmd_valid = 1; cmd = {3'd1, 13'd77}; frame_done = 1;
    repeat (2) @(posedge clk_in);
    model_reset();
    #1;
    cmd_valid = 0; frame_done = 0;
    @(negedge clk_in);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (running !== 1'b0 || integration_clock_count !== 32'd5000 || state !== 2'd0 ||
        frame_count !== 16'd0 || cmd_ack !== 1'b0 || cmd_error !== 1'b0) begin
      failures++;
      $display("FAIL reset got run=%b integ=%0d st=%0d fc=%0d ack=%b err=%b exp 0 5000 0 0 0 0",
               running, integration_clock_count, state, frame_count, cmd_ack, cmd_error);
    end
  endtask

  task automatic test_start();
    cyc(1, 1, 1000, 0);
    checks++;
    if (integration_clock_count !== 32'd4000 || running !== 1'b1 || cmd_ack !== 1'b1 ||
        cmd_error !== 1'b0 || state !== 2'd1) begin
      failures++;
      $display("FAIL start got integ=%0d run=%b ack=%b err=%b st=%0d exp 4000 1 1 0 1",
               integration_clock_count, running, cmd_ack, cmd_error, state);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (cmd_ack !== 1'b0) begin
      failures++; $display("FAIL ack_pulse_width got=%b exp=0", cmd_ack);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    checks++;
    if (frame_count !== 16'd3 || state !== 2'd1) begin
      failures++; $display("FAIL start_frames got fc=%0d st=%0d exp 3 1", frame_count, state);
    end
  endtask

  task automatic test_burst();
    cyc(1, 3, 2, 0);
    checks++;
    if (state !== 2'd2 || frame_count !== 16'd0 || integration_clock_count !== 32'd4000) begin
      failures++;
      $display("FAIL burst_start got st=%0d fc=%0d integ=%0d exp 2 0 4000",
               state, frame_count, integration_clock_count);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (state !== 2'd2 || running !== 1'b1 || frame_count !== 16'd1) begin
      failures++;
      $display("FAIL burst_mid got st=%0d run=%b fc=%0d exp 2 1 1", state, running, frame_count);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || frame_count !== 16'd2) begin
      failures++;
      $display("FAIL burst_end got st=%0d run=%b fc=%0d exp 0 0 2", state, running, frame_count);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (frame_count !== 16'd2 || state !== 2'd0) begin
      failures++; $display("FAIL idle_frame_ignored got fc=%0d st=%0d exp 2 0", frame_count, state);
    end
  endtask

  task automatic test_stop_abort();
    cyc(1, 1, 10, 0);
    cyc(1, 2, 0, 0);
    checks++;
    if (state !== 2'd3 || running !== 1'b1 || cmd_ack !== 1'b1) begin
      failures++;
      $display("FAIL stop got st=%0d run=%b ack=%b exp 3 1 1", state, running, cmd_ack);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || running !== 1'b0) begin
      failures++; $display("FAIL stop_frame got st=%0d run=%b exp 0 0", state, running);
    end
    cyc(1, 1, 10, 0);
    cyc(1, 5, 0, 0);
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || cmd_ack !== 1'b1) begin
      failures++;
      $display("FAIL abort got st=%0d run=%b ack=%b exp 0 0 1", state, running, cmd_ack);
    end
  endtask

  task automatic test_set_integ();
    cyc(1, 1, 1000, 0);
    cyc(1, 4, 50, 0);
    checks++;
    if (integration_clock_count !== 32'd4000 || cmd_ack !== 1'b1) begin
      failures++;
      $display("FAIL set_deferred got integ=%0d ack=%b exp 4000 1", integration_clock_count, cmd_ack);
    end
    cyc(0, 0, 0, 1);
    checks++;
    if (integration_clock_count !== 32'd200) begin
      failures++; $display("FAIL set_applied got=%0d exp=200", integration_clock_count);
    end
    cyc(1, 5, 0, 0);
    cyc(1, 4, 25, 0);
    checks++;
    if (integration_clock_count !== 32'd100 || state !== 2'd0) begin
      failures++;
      $display("FAIL set_idle got integ=%0d st=%0d exp 100 0", integration_clock_count, state);
    end
  endtask

  task automatic test_errors();
    int ops[3]  = '{1, 7, 4};
    int vals[3] = '{0, 5, 0};
    for (int i = 0; i < 3; i++) begin
      cyc(1, ops[i], vals[i], 0);
      checks++;
      if (cmd_error !== 1'b1 || cmd_ack !== 1'b0 || state !== 2'd0 ||
          integration_clock_count !== 32'd100 || running !== 1'b0) begin
        failures++;
        $display("FAIL reject op=%0d got err=%b ack=%b st=%0d integ=%0d run=%b exp 1 0 0 100 0",
                 ops[i], cmd_error, cmd_ack, state, integration_clock_count, running);
      end
    end
    cyc(1, 0, 123, 0);
    checks++;
    if (cmd_error !== 1'b0 || cmd_ack !== 1'b0) begin
      failures++; $display("FAIL noop got err=%b ack=%b exp 0 0", cmd_error, cmd_ack);
    end
  endtask

  task automatic test_collision();
    cyc(1, 3, 2, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 100, 1);
    checks++;
    if (state !== 2'd1 || frame_count !== 16'd0 || integration_clock_count !== 32'd400 ||
        running !== 1'b1 || cmd_ack !== 1'b1) begin
      failures++;
      $display("FAIL collision got st=%0d fc=%0d integ=%0d run=%b ack=%b exp 1 0 400 1 1",
               state, frame_count, integration_clock_count, running, cmd_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      int  r, op, val;
      bit  v, fd;
      v  = ($urandom % 10) < 3;
      fd = ($urandom % 10) < 3;
      op = $urandom % 8;
      r  = $urandom % 10;
      val = (r == 0) ? 0 : (r < 6) ? int'($urandom_range(1, 4)) : int'($urandom % 8192);
      cyc(v, op, val, fd);
      checks++;
      if (state !== 2'(m_state) || running !== (m_state != 0) ||
          integration_clock_count !== 32'(m_integ) || frame_count !== 16'(m_fc) ||
          cmd_ack !== exp_ack || cmd_error !== exp_err) begin
        failures++;
        $display("FAIL random cyc=%0d got st=%0d run=%b integ=%0d fc=%0d ack=%b err=%b exp %0d %0d %0d %0d %0d %0d",
                 i, state, running, integration_clock_count, frame_count, cmd_ack, cmd_error,
                 m_state, m_state != 0, m_integ, m_fc, exp_ack, exp_err);
      end
    end
  endtask

  task automatic test_reset_from_run();
    cyc(1, 1, 300, 0);
    cyc(1, 4, 9, 0);
    cyc(0, 0, 0, 1);
    do_reset();
    cyc(1, 2, 0, 0);
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || integration_clock_count !== 32'd5000 ||
        frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_from_run got st=%0d run=%b integ=%0d fc=%0d exp 0 0 5000 0",
               state, running, integration_clock_count, frame_count);
    end
  endtask

  initial begin
    reset_n = 0; cmd = '0; cmd_valid = 0; frame_done = 0;
    model_reset();
    test_reset();
    test_start();
    test_burst();
    test_stop_abort();
    test_set_integ();
    test_errors();
    test_collision();
    test_random();
    test_reset_from_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
